// File: rtl/rv32i_defs.sv
// ============================================================================
// Module      : rv32i_defs (package)
// Description : RV32I datapath widths and the fetch buffer entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_defs;

    localparam int XLEN        = 32;
    localparam int INSTR_WIDTH = 32;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] next_fetch_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_memory_if.sv
// ============================================================================
// Module      : instr_memory_if (interface)
// Description : Combinational instruction memory read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_memory_if;
    logic [31:0] addr;
    logic [31:0] instr;

    modport cpu (output addr, input  instr);
    modport mem (input  addr, output instr);
endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Prefetch buffer with wrap-bit pointers and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import rv32i_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    fetch_entry_t  mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    // The extra MSB distinguishes full from empty when the index bits match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Sequential instruction prefetcher with redirect/flush support.
//               Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import rv32i_defs::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    instr_memory_if.cpu            instr_mem_if,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic                   misalign_err
);

    localparam logic [XLEN-1:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] target_pc;
    logic            halted;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic halt_q, halt_d;

    // A misaligned target is kept as-is; fetching stops until reset.
    assign target_pc = redirect_pc;
    assign halt_d    = halt_q | (redirect_valid & (|(redirect_pc & ~C_ALIGN_MASK)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) halt_q <= 1'b0;
        else       halt_q <= halt_d;
    end

    assign halted       = halt_q;
    assign misalign_err = halt_q;
`else
    assign target_pc    = redirect_pc & C_ALIGN_MASK;
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign instr_mem_if.addr = fetch_pc_q;

    assign pop  = out_valid && out_ready;
    assign push = (!fifo_full || pop) && !redirect_valid && !halted;

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = instr_mem_if.instr;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid)
            fetch_pc_d = target_pc;
        else if (push)
            fetch_pc_d = next_fetch_pc(fetch_pc_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) fetch_pc_q <= RESET_PC;
        else       fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(
        .DEPTH   (BUF_DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Outputs read zero while empty so reset leaves them cleared.
    assign out_valid = !fifo_empty;
    assign out_pc    = out_valid ? head_entry.pc    : '0;
    assign out_instr = out_valid ? head_entry.instr : '0;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Randomized bench for instr_fetch_unit with a queue reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk;
    logic        rstn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    instr_memory_if mem_if ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    assign mem_if.instr = mem_word(mem_if.addr);

    instr_fetch_unit #(
        .RESET_PC       (RESET_PC),
        .BUF_DEPTH      (BUF_DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .instr_mem_if   (mem_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: buffer contents as a list of pcs, plus next fetch address.
    logic [31:0] m_q[$];
    logic [31:0] m_fetch;
    logic        m_halt;

    task automatic model_reset();
        m_q.delete();
        m_fetch = RESET_PC;
        m_halt  = 1'b0;
    endtask

    task automatic model_clock(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] dummy;
        if (rv) begin
            m_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) m_halt = 1'b1;
            m_fetch = rpc;
`else
            m_fetch = {rpc[31:2], 2'b00};
`endif
        end else begin
            if (m_q.size() > 0 && rdy) dummy = m_q.pop_front();
            if (m_q.size() < BUF_DEPTH && !m_halt) begin
                m_q.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() > 0)});
        if (m_q.size() > 0) begin
            chk("out_pc", out_pc, m_q[0]);
            chk("out_instr", out_instr, mem_word(m_q[0]));
        end
        chk("fetch_addr", mem_if.addr, m_fetch);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_halt});
    endtask

    // Called at posedge+1; checks, drives, crosses one edge, returns at posedge+1.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        check_outputs();
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        model_clock(rv, rpc, rdy);
        #1;
    endtask

    task automatic async_reset();
        #3 rstn = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("rst_fetch_addr", mem_if.addr, RESET_PC);
        model_reset();
        redirect_valid = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("init_out_valid", {31'b0, out_valid}, 32'd0);
        chk("init_out_pc", out_pc, 32'd0);
        chk("init_misalign", {31'b0, misalign_err}, 32'd0);
        chk("init_fetch_addr", mem_if.addr, RESET_PC);
        rstn = 1'b1;

        // Reset release streaming with decode always ready
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

        // Back-pressure: fill, stall, then drain without gaps
        async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

        // Redirect while full
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 32'h0000_0040, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // Back-to-back redirects, last wins
        cycle(1'b1, 32'h0000_1000, 1'b1);
        cycle(1'b1, 32'h0000_2000, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        // Address wrap at the top of memory
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // Misaligned redirect
        cycle(1'b1, 32'h0000_0042, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

        // Mid-stream reset
        async_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic        rdy;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 5) == 0) rpc = 32'hFFFF_FFF8;
            if (i % 80 == 79) async_reset();
            else              cycle(rv, rpc, rdy);
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
